// File: rtl/fifo_wr_arb.sv
// Round-robin write-port arbiter feeding the asyn_fifo write side.
// Grants one requester at a time for bursts of up to MAX_BURST words, gated on wfull.
module fifo_wr_arb #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 4,
  localparam int IDW = $clog2(NUM_REQ),
  localparam int BCW = $clog2(MAX_BURST + 1)
) (
  input  logic                          wclk,
  input  logic                          wrst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          wfull,
  output logic                          winc,
  output logic [DATA_WIDTH-1:0]         wdata,
  output logic [IDW-1:0]                gnt_id,
  output logic                          busy,
  output logic [15:0]                   wr_count
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                             r_state, w_state_nxt;
  logic [IDW-1:0]                     r_gnt_id, w_sel;
  logic [BCW-1:0]                     r_beat_cnt;
  logic [15:0]                        r_wr_count;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] w_req_data;
  logic                               w_any, w_gvalid, w_xfer, w_last, w_busy;

  assign w_req_data = req_data;
  assign w_any      = |req_valid;
  assign w_gvalid   = req_valid[r_gnt_id];
  assign w_busy     = (r_state == BURST);

  // Descending scan so the lowest offset after the last holder wins.
  always_comb begin
    w_sel = r_gnt_id;
    for (int k = NUM_REQ; k >= 1; k--) begin
      logic [IDW-1:0] li;
      li = IDW'((int'(r_gnt_id) + k) % NUM_REQ);
      if (req_valid[li]) w_sel = li;
    end
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_xfer      = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      IDLE: if (w_any) w_state_nxt = BURST;
      BURST: begin
        w_xfer = w_gvalid && !wfull;
        w_last = w_xfer && (r_beat_cnt == BCW'(MAX_BURST - 1));
        if (!w_gvalid || w_last) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_gnt_id   <= IDW'(NUM_REQ - 1);
      r_beat_cnt <= '0;
      r_wr_count <= '0;
    end else begin
      if (r_state == IDLE && w_any) begin
        r_gnt_id   <= w_sel;
        r_beat_cnt <= '0;
      end
      if (w_xfer) begin
        r_beat_cnt <= r_beat_cnt + BCW'(1);
        r_wr_count <= r_wr_count + 16'd1;
      end
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_rdy
    assign req_ready[i] = w_busy && (r_gnt_id == IDW'(i)) && !wfull;
  end

  assign winc     = w_xfer;
  assign wdata    = w_req_data[r_gnt_id];
  assign gnt_id   = r_gnt_id;
  assign busy     = w_busy;
  assign wr_count = r_wr_count;

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Scoreboard bench for fifo_wr_arb: directed bursts, stalls, release, reset, random stream.
module tb_fifo_wr_arb;
  localparam int N = 4, DW = 32, MB = 4;

  logic          wclk = 1'b0, wrst_n = 1'b0;
  logic [N-1:0]  req_valid = '0, req_ready;
  logic [N*DW-1:0] req_data = '0;
  logic          wfull = 1'b0, winc, busy;
  logic [DW-1:0] wdata;
  logic [1:0]    gnt_id;
  logic [15:0]   wr_count;

  always #5 wclk = ~wclk;

  fifo_wr_arb #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .wfull(wfull), .winc(winc), .wdata(wdata),
    .gnt_id(gnt_id), .busy(busy), .wr_count(wr_count));

  int checks = 0, errors = 0;
  logic [N-1:0] en = '0, acc;
  logic full_v = 1'b0;
  int seq[N], lim[N], rseq[N];
  int rwords = 0;
  bit rand_mode = 1'b0;
  logic [DW-1:0] exp_q[$];
  logic [N-1:0] m_allow;
  logic [DW-1:0] m_e;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] word(int i, int s);
    return DW'((i << 16) | s);
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = en[i] && (seq[i] <= lim[i]);
      req_data[i*DW +: DW] = word(i, seq[i]);
    end
    wfull = full_v;
  endtask

  // Inputs change just after posedge; outputs sampled at negedge.
  task automatic step();
    acc = req_valid & req_ready;
    @(posedge wclk); #1;
    for (int i = 0; i < N; i++) if (acc[i]) seq[i]++;
    drive();
    @(negedge wclk);
  endtask

  task automatic reset_hold(input logic [N-1:0] e);
    wrst_n = 1'b0;
    en = e; full_v = 1'b0;
    for (int i = 0; i < N; i++) begin seq[i] = 1; lim[i] = 60000; end
    exp_q.delete();
    drive();
    step(); step();
  endtask

  task automatic release_rst(input logic [N-1:0] e);
    @(posedge wclk); #1;
    wrst_n = 1'b1; en = e;
    drive();
    @(negedge wclk);
  endtask

  task automatic push_run(int r, int first, int cnt);
    for (int s = first; s < first + cnt; s++) exp_q.push_back(word(r, s));
  endtask

  always @(negedge wclk) begin
    chk("winc_wfull", 32'(winc & wfull), 32'd0);
    m_allow = busy ? (N'(1) << gnt_id) : '0;
    chk("ready_gnt", 32'(req_ready & ~m_allow), 32'd0);
    if (winc) begin
      if (rand_mode) begin
        chk("rand_data", wdata, word(int'(gnt_id), rseq[gnt_id]));
        rseq[gnt_id]++;
        rwords++;
      end else if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_empty act=%0h exp=none", wdata);
      end else begin
        m_e = exp_q.pop_front();
        chk("sb_data", wdata, m_e);
        chk("sb_gnt", 32'(gnt_id), m_e >> 16);
      end
    end
  end

  int pat[10] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 1};

  initial begin
    // reset state with all requesters asking
    reset_hold(4'hF);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_winc", 32'(winc), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_wrcnt", 32'(wr_count), 32'd0);
    chk("rst_gnt", 32'(gnt_id), 32'd3);

    // single requester
    for (int i = 0; i < N; i++) seq[i] = 1;
    push_run(0, 1, 8);
    release_rst(4'b0001);
    for (int c = 0; c < 10; c++) begin
      if (c > 0) step();
      chk("t1_winc", 32'(winc), 32'(pat[c]));
      if (c > 0) chk("t1_gnt", 32'(gnt_id), 32'd0);
    end
    en = '0; step();
    chk("t1_wrcnt", 32'(wr_count), 32'd8);
    step();
    chk("t1_sb_left", 32'(exp_q.size()), 32'd0);

    // all four, round robin
    reset_hold('0);
    push_run(0, 1, 4); push_run(1, 1, 4); push_run(2, 1, 4); push_run(3, 1, 4);
    push_run(0, 5, 4);
    release_rst(4'hF);
    for (int c = 0; c < 20; c++) step();
    chk("t2_wrcnt16", 32'(wr_count), 32'd16);
    for (int c = 0; c < 4; c++) step();
    en = '0; step(); step();
    chk("t2_wrcnt20", 32'(wr_count), 32'd20);
    chk("t2_sb_left", 32'(exp_q.size()), 32'd0);

    // wfull stall after beat 2
    reset_hold('0);
    push_run(0, 1, 4);
    release_rst(4'b0001);
    step(); step();
    full_v = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("t3_stall_winc", 32'(winc), 32'd0);
      chk("t3_stall_ready", 32'(req_ready), 32'd0);
      chk("t3_stall_beat", 32'(dut.r_beat_cnt), 32'd2);
      chk("t3_stall_busy", 32'(busy), 32'd1);
    end
    full_v = 1'b0;
    step(); chk("t3_w3", 32'(winc), 32'd1);
    step(); chk("t3_w4", 32'(winc), 32'd1);
    en = '0; step();
    chk("t3_idle", 32'(busy), 32'd0);
    step();
    chk("t3_wrcnt", 32'(wr_count), 32'd4);
    chk("t3_sb_left", 32'(exp_q.size()), 32'd0);

    // requester 2 releases after one word, 3 follows
    reset_hold('0);
    lim[2] = 1;
    exp_q.push_back(word(2, 1));
    push_run(3, 1, 4);
    release_rst(4'b1100);
    step();
    chk("t4_gnt2", 32'(gnt_id), 32'd2);
    chk("t4_w1", 32'(winc), 32'd1);
    step();
    chk("t4_rel_winc", 32'(winc), 32'd0);
    chk("t4_rel_busy", 32'(busy), 32'd1);
    step();
    chk("t4_idle_busy", 32'(busy), 32'd0);
    chk("t4_idle_winc", 32'(winc), 32'd0);
    chk("t4_wrcnt1", 32'(wr_count), 32'd1);
    step();
    chk("t4_gnt3", 32'(gnt_id), 32'd3);
    chk("t4_w3", 32'(winc), 32'd1);
    for (int c = 0; c < 3; c++) step();
    en = '0; step(); step();
    chk("t4_wrcnt5", 32'(wr_count), 32'd5);
    chk("t4_sb_left", 32'(exp_q.size()), 32'd0);

    // async reset in beat 2
    reset_hold('0);
    push_run(0, 1, 2);
    release_rst(4'b0001);
    step(); step();
    #1 wrst_n = 1'b0;
    #1;
    chk("t5_rst_winc", 32'(winc), 32'd0);
    chk("t5_rst_ready", 32'(req_ready), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_wrcnt", 32'(wr_count), 32'd0);
    en = 4'b1010;
    for (int i = 0; i < N; i++) seq[i] = 1;
    drive();
    step();
    chk("t5_hold_winc", 32'(winc), 32'd0);
    step();
    chk("t5_hold_wrcnt", 32'(wr_count), 32'd0);
    push_run(1, 1, 4); push_run(3, 1, 4);
    release_rst(4'b1010);
    chk("t5_rel_winc", 32'(winc), 32'd0);
    step();
    chk("t5_gnt1", 32'(gnt_id), 32'd1);
    chk("t5_w1", 32'(winc), 32'd1);
    for (int c = 0; c < 8; c++) step();
    en = '0; step(); step();
    chk("t5_wrcnt8", 32'(wr_count), 32'd8);
    chk("t5_sb_left", 32'(exp_q.size()), 32'd0);

    // random valid / wfull stream, per-requester order check
    reset_hold('0);
    for (int i = 0; i < N; i++) rseq[i] = 1;
    rwords = 0;
    rand_mode = 1'b1;
    release_rst('0);
    for (int c = 0; c < 20000 && rwords < 1000; c++) begin
      en = N'($urandom);
      full_v = ($urandom_range(0, 3) == 0);
      step();
    end
    en = '0; full_v = 1'b0;
    step(); step();
    rand_mode = 1'b0;
    chk("rand_budget", 32'(rwords >= 1000), 32'd1);
    chk("rand_wrcnt", 32'(wr_count), 32'(rwords[15:0]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
